// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_* datapath stages: default widths, word type
// and the level-counter width helper.
package pipe_pkg;

  localparam int W_DATA_DEF     = 32;
  localparam int PIPE_DEPTH_DEF = 4;

  typedef logic [W_DATA_DEF-1:0] pipe_word_t;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_in_fifo_if.sv
// Valid/ready word stream. The master drives valid/data; the slave drives ready.
interface pipe_in_fifo_if
  import pipe_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF
);

  logic              valid;
  logic              ready;
  logic [W_DATA-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_in_fifo_mem.sv
// DEPTH x W_DATA storage array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module pipe_in_fifo_mem
  import pipe_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int DEPTH  = PIPE_DEPTH_DEF,
  localparam int W_IDX = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [W_IDX-1:0]  i_waddr,
  input  logic [W_DATA-1:0] i_wdata,
  input  logic [W_IDX-1:0]  i_raddr,
  output logic [W_DATA-1:0] o_rdata
);

  logic [W_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_in_fifo.sv
// Elastic input buffer feeding pipe_pal's c operand: DEPTH-entry in-order FIFO
// with registered outputs. Optional PIPE_IN_FIFO_BYPASS_EN gives 0-cycle pass-through when empty.
module pipe_in_fifo
  import pipe_pkg::*;
#(
  parameter int  W_DATA = W_DATA_DEF,
  parameter int  DEPTH  = PIPE_DEPTH_DEF,
  localparam int W_LVL  = lvl_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             resetn,
  input  logic             i_flush,
  pipe_in_fifo_if.slave    s_if,
  pipe_in_fifo_if.master   m_if,
  output logic [W_LVL-1:0] o_level
);

  localparam int W_IDX = $clog2(DEPTH);
  localparam int W_PTR = W_IDX + 1;

  logic [W_PTR-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [W_LVL-1:0]  r_level, w_level_nxt;
  logic              r_s_ready, r_m_valid;
  logic [W_DATA-1:0] r_m_data, w_mem_rdata, w_head_nxt;
  logic              w_empty, w_bypass, w_push, w_pop;
  logic              w_empty_nxt, w_full_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);

`ifdef PIPE_IN_FIFO_BYPASS_EN
  assign w_bypass   = w_empty && !i_flush && s_if.valid && r_s_ready && m_if.ready;
  assign m_if.valid = (w_empty && !i_flush) ? (s_if.valid && r_s_ready) : r_m_valid;
  assign m_if.data  = (w_empty && !i_flush) ? s_if.data : r_m_data;
`else
  assign w_bypass   = 1'b0;
  assign m_if.valid = r_m_valid;
  assign m_if.data  = r_m_data;
`endif

  assign w_push = s_if.valid && r_s_ready && !i_flush && !w_bypass;
  assign w_pop  = r_m_valid && m_if.ready && !i_flush;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (i_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + W_PTR'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + W_PTR'(1);
      if (w_push && !w_pop)      w_level_nxt = r_level + W_LVL'(1);
      else if (w_pop && !w_push) w_level_nxt = r_level - W_LVL'(1);
    end
  end

  assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt  = (w_wr_ptr_nxt[W_IDX-1:0] == w_rd_ptr_nxt[W_IDX-1:0]) &&
                       (w_wr_ptr_nxt[W_IDX] != w_rd_ptr_nxt[W_IDX]);

  // A push landing on the next head slot can only happen when the FIFO would
  // otherwise be empty, so the incoming word becomes the head directly.
  assign w_head_nxt = (w_push && (r_wr_ptr[W_IDX-1:0] == w_rd_ptr_nxt[W_IDX-1:0]))
                      ? s_if.data : w_mem_rdata;

  pipe_in_fifo_mem #(
    .W_DATA (W_DATA),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[W_IDX-1:0]),
    .i_wdata (s_if.data),
    .i_raddr (w_rd_ptr_nxt[W_IDX-1:0]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_level_nxt;
      r_s_ready <= !w_full_nxt;
      r_m_valid <= !w_empty_nxt;
      if (!w_empty_nxt) r_m_data <= w_head_nxt;
    end
  end

  assign s_if.ready = r_s_ready;
  assign o_level    = r_level;

endmodule

// File: doc/pipe_in_fifo.md
# pipe_in_fifo

Elastic input stage that sits directly upstream of the `pipe_pal` datapath stage. It accepts `W_DATA`-wide words from the producer over a valid/ready handshake and buffers up to `DEPTH` words in order. It presents them to `pipe_pal`'s `c` operand port over a second valid/ready handshake. The stage decouples producer stalls from the datapath and reports its fill level for flow-control monitoring.

## Interface
- `W_DATA`, 32, data word width; matches `pipe_pal`'s `W_DATA`.
- `DEPTH`, 4, number of storage entries; power of two, ≥ 2.
- `W_LVL` (localparam), `$clog2(DEPTH+1)`, width of the level output.

- `i_clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `i_flush`  in  1  synchronous discard of all buffered words.
- `s_valid`  in  1  producer word valid.
- `s_ready`  out  1  stage can accept a word.
- `s_data`  in  `W_DATA`  producer word.
- `m_valid`  out  1  word available to `pipe_pal`.
- `m_ready`  in  1  `pipe_pal` accepts the word.
- `m_data`  out  `W_DATA`  word to `pipe_pal` `c`.
- `o_level`  out  `W_LVL`  number of words currently held, 0..`DEPTH`.

## Operation
- Reset (`resetn`=0, asynchronous): `m_valid`=0, `s_ready`=0 while reset is held, `o_level`=0, `m_data`=0, read and write pointers =0. `s_ready` rises on the first clock edge after reset release.
- Push: `s_valid && s_ready` at a rising edge stores `s_data` at `wr_ptr`; `wr_ptr` increments modulo `DEPTH`.
- Pop: `m_valid && m_ready` at a rising edge retires the head word; `rd_ptr` increments modulo `DEPTH`.
- Pointers carry one extra wrap bit. Empty = pointers equal. Full = indices equal and wrap bits differ.
- `o_level` = registered count. It changes by +1 on push only, −1 on pop only, and is unchanged on push+pop.
- `s_ready` = !full, registered. It does not depend on `m_ready`. When full, a same-cycle pop does not allow a same-cycle push.
- Simultaneous push+pop when not full and not empty: both occur, and the level is unchanged.
- `m_data` is registered from the head entry and held stable while `m_valid && !m_ready`. Data and valid must not change until accepted.
- Flush: `i_flush`=1 at an edge sets pointers and level to 0 and `m_valid` to 0. A push or pop in the same cycle is discarded. Flush has priority over all other events.
- Producer contract: the producer holds `s_data` stable while `s_valid && !s_ready`. This stage does not check the contract.

## Timing
- Push-to-output latency is 1 cycle: a word pushed at edge N into an empty stage gives `m_valid`=1 with that word after edge N.
- Throughput is 1 word/cycle when `m_ready` is held at 1 and the stage is not full.
- `s_ready` falls in the cycle after the push that fills the stage. It rises in the cycle after the first pop from full.
- `o_level` is valid one cycle after the causing edge, the same cycle as `m_valid` and `s_ready`.
- Reset asserted mid-transfer drops all contents immediately. There is no partial-word state.

## Configuration
- `PIPE_IN_FIFO_BYPASS_EN` defined:
  - When the stage is empty and not flushing, `m_valid`=`s_valid` and `m_data`=`s_data` combinationally.
  - If `m_ready`=1 in that cycle, the word passes through without being stored, giving 0-cycle latency.
  - Otherwise the word is stored normally.
- `PIPE_IN_FIFO_BYPASS_EN` undefined: the behaviour above, with all outputs registered.

## Structure
- Shared package `pipe_pkg`:
  - `W_DATA_DEF`=32
  - `PIPE_DEPTH_DEF`=4
  - typedef `pipe_word_t` (`logic [W_DATA_DEF-1:0]`)
  - function `lvl_width(depth)` returning `$clog2(depth+1)`
- One sub-module, `pipe_in_fifo_mem`: a `DEPTH`×`W_DATA` register array with one write port and one asynchronous read port. It has no reset on its contents. Pointers, level and handshake logic stay in `pipe_in_fifo`.

## Test plan
All scenarios use `DEPTH`=4 and `W_DATA`=32.
- Reset release, no traffic: `m_valid`=0, `o_level`=0, `s_ready`=1 from the first edge after `resetn` rises; `m_data`=0.
- Push 32'hA5A5_0001..0004 with `m_ready`=0: `o_level` goes 1,2,3,4; `s_ready`=0 after the 4th push; a 5th word 32'hDEAD_BEEF offered with `s_valid` held is not taken.
- From full, `m_ready`=1 for 4 cycles: outputs 0001,0002,0003,0004 in order; `s_ready`=1 the cycle after the first pop; `m_valid`=0 after the last.
- Level 2, then `s_valid`=`m_ready`=1 for 10 cycles with an incrementing pattern: `o_level` stays 2; output sequence equals input sequence delayed by 2 words; no word is lost across pointer wrap.
- Level 3, with `i_flush`=1, `s_valid`=1 and `m_ready`=1 in the same cycle: next cycle `o_level`=0 and `m_valid`=0; the pushed word never appears at the output.
- Bypass build, empty stage, `s_valid`=`m_ready`=1 with 32'h1234_5678: `m_data`=32'h1234_5678 and `m_valid`=1 in the same cycle; `o_level` stays 0.
